// File: rtl/note_period_decoder.sv
// Recovers which of the 8 synth notes is present in an 8-bit sample stream by timing
// rising mid-scale crossings (with hysteresis) and matching the period to the note table.
module note_period_decoder #(
    parameter logic [7:0]  LO_THR    = 8'd112,
    parameter logic [7:0]  HI_THR    = 8'd144,
    parameter int          TOL       = 2,
    parameter int          CONFIRM   = 2,
    // Period is compared as per_cnt >> PER_SHIFT against the nominal table.
    parameter int unsigned PER_SHIFT = 8,
    parameter logic [16:0] PER_MAX   = 17'h1FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  sample,
    output logic [7:0]  note_out,
    output logic        note_valid,
    output logic        note_change,
    output logic [16:0] period_out
);

    typedef enum logic {ARM_LOW, ARMED_HIGH} cross_state_t;

    localparam int         NOMINAL [8] = '{374, 334, 297, 281, 250, 223, 199, 188};
    localparam logic [2:0] CONFIRM_C   = 3'(CONFIRM);

    cross_state_t state;
    logic [7:0]   sample_q;
    logic         cross_pulse;
    logic         first_seen;
    logic         timeout_done;
    logic [3:0]   cand;
    logic [2:0]   match_cnt;
    logic [16:0]  per_cnt;

    logic [3:0]   bin;
    logic [3:0]   cand_nx;
    logic [2:0]   match_nx;
    logic [7:0]   note_nx;

    // Bin 1..8 whose nominal lies within TOL of the scaled period, else 0.
    function automatic logic [3:0] classify(input logic [16:0] per);
        logic [3:0] b;
        int         diff;
        b = '0;
        for (int k = 7; k >= 0; k--) begin
            diff = int'(per >> PER_SHIFT) - NOMINAL[k];
            if (diff <= TOL && diff >= -TOL) b = 4'(k + 1);
        end
        return b;
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        bin      = classify(per_cnt);
        cand_nx  = cand;
        match_nx = match_cnt;
        note_nx  = note_out;
        if (bin == 4'd0) begin
            cand_nx  = '0;
            match_nx = '0;
            note_nx  = '0;
        end else begin
            if (bin == cand) begin
                match_nx = (match_cnt >= CONFIRM_C) ? CONFIRM_C : match_cnt + 3'd1;
            end else begin
                cand_nx  = bin;
                match_nx = 3'd1;
            end
            if (match_nx == CONFIRM_C) note_nx = 8'd1 << (cand_nx - 4'd1);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARM_LOW;
            sample_q     <= '0;
            cross_pulse  <= 1'b0;
            first_seen   <= 1'b0;
            timeout_done <= 1'b0;
            cand         <= '0;
            match_cnt    <= '0;
            per_cnt      <= '0;
            note_out     <= '0;
            note_valid   <= 1'b0;
            note_change  <= 1'b0;
            period_out   <= '0;
        end else if (ena) begin
            sample_q    <= sample;
            cross_pulse <= 1'b0;
            note_change <= 1'b0;

            unique case (state)
                ARM_LOW: if (sample_q >= HI_THR) begin
                    state       <= ARMED_HIGH;
                    cross_pulse <= 1'b1;
                end
                ARMED_HIGH: if (sample_q < LO_THR) state <= ARM_LOW;
                default: state <= ARM_LOW;
            endcase

            if (cross_pulse) begin
                per_cnt      <= 17'd1;
                timeout_done <= 1'b0;
                if (first_seen) begin
                    period_out  <= per_cnt;
                    cand        <= cand_nx;
                    match_cnt   <= match_nx;
                    note_out    <= note_nx;
                    note_valid  <= |note_nx;
                    note_change <= (note_nx != note_out);
                end else begin
                    first_seen <= 1'b1;
                end
            end else if (per_cnt != PER_MAX) begin
                per_cnt <= per_cnt + 17'd1;
            end else if (!timeout_done) begin
                // Silence or DC: drop the note once, then wait for the next crossing.
                timeout_done <= 1'b1;
                first_seen   <= 1'b0;
                cand         <= '0;
                match_cnt    <= '0;
                note_out     <= '0;
                note_valid   <= 1'b0;
                note_change  <= (note_out != 8'd0);
            end
        end else begin
            note_change <= 1'b0;
        end
    end

endmodule

// File: tb/tb_note_period_decoder.sv
// Directed bench for note_period_decoder; the period scale and saturation point are
// shrunk (PER_SHIFT=2, PER_MAX=4095) so each note period is 4*N_k cycles.
module tb_note_period_decoder;

    localparam int          P_SHIFT = 2;
    localparam logic [16:0] P_MAX   = 17'd4095;
    localparam int          P_A     = 892;   // 4*223

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [7:0]  sample;
    logic [7:0]  note_out;
    logic        note_valid;
    logic        note_change;
    logic [16:0] period_out;

    int total = 0;
    int bad   = 0;
    int chg_total;

    note_period_decoder #(
        .LO_THR(8'd112), .HI_THR(8'd144), .TOL(2), .CONFIRM(2),
        .PER_SHIFT(P_SHIFT), .PER_MAX(P_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sample(sample),
        .note_out(note_out), .note_valid(note_valid),
        .note_change(note_change), .period_out(period_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (note_change) chg_total <= chg_total + 1;

    typedef struct {
        int          period;
        int          reps;
        bit          glitch;
        logic [7:0]  note;
        logic [16:0] per;
        int          chg;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic [7:0] v);
        @(negedge clk);
        sample = v;
    endtask

    function automatic logic [7:0] wave_val(input int p, input int i, input bit glitch);
        logic [7:0] v;
        v = (i < p / 2) ? 8'hFF : 8'h00;
        if (glitch && (i % 100) == 50) v = (i < p / 2) ? 8'd113 : 8'd143;
        return v;
    endfunction

    // One square-wave period; the crossing completes at sample index 0.
    task automatic wave(input int p, input bit glitch, input int gap_at,
                        input bit watch, input logic [7:0] nb, input logic [7:0] na);
        logic [16:0] held;
        for (int i = 0; i < p; i++) begin
            drv(wave_val(p, i, glitch));
            if (watch && i == 2) check("pre_latency", 32'(note_out), 32'(nb));
            if (watch && i == 3) begin
                check("note_update", 32'(note_out), 32'(na));
                check("change_pulse", 32'(note_change), 32'(na != nb));
            end
            if (watch && i == 4) check("change_clear", 32'(note_change), 32'd0);
            if (i == gap_at) begin
                held = period_out;
                ena  = 1'b0;
                repeat (1000) @(negedge clk);
                check("ena_hold_period", 32'(period_out), 32'(held));
                ena = 1'b1;
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time bound");
        $fatal(1);
    end

    initial begin
        int  base;
        int  k;
        bit  seen;

        //           period reps glitch note   period_out chg
        vecs[0] = '{1496, 3, 1'b0, 8'h01, 17'd1496, 1};  // C established over A
        vecs[1] = '{ 752, 2, 1'b0, 8'h01, 17'd752,  0};  // one C1046 period: C holds
        vecs[2] = '{ 752, 1, 1'b0, 8'h80, 17'd752,  1};  // second C1046 period: switch
        vecs[3] = '{ 900, 2, 1'b0, 8'h80, 17'd900,  0};  // d=225 candidate A
        vecs[4] = '{ 904, 1, 1'b0, 8'h20, 17'd900,  1};  // 900 confirmed as A
        vecs[5] = '{P_A,  1, 1'b0, 8'h00, 17'd904,  1};  // d=226 out of tolerance
        vecs[6] = '{P_A,  2, 1'b1, 8'h20, 17'd892,  1};  // glitched wave still decodes
        vecs[7] = '{P_A,  2, 1'b1, 8'h20, 17'd892,  0};

        rst_n  = 1'b0;
        ena    = 1'b1;
        sample = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_note", 32'(note_out), 32'd0);
        check("reset_valid", 32'(note_valid), 32'd0);
        check("reset_change", 32'(note_change), 32'd0);
        check("reset_period", 32'(period_out), 32'd0);
        rst_n = 1'b1;
        repeat (4) drv(8'h00);

        // Note A needs three crossings with CONFIRM=2.
        base = chg_total;
        wave(P_A, 1'b0, -1, 1'b0, 8'h00, 8'h00);
        check("t1_cross1_note", 32'(note_out), 32'd0);
        check("t1_cross1_period", 32'(period_out), 32'd0);
        wave(P_A, 1'b0, -1, 1'b0, 8'h00, 8'h00);
        check("t1_cross2_note", 32'(note_out), 32'd0);
        check("t1_cross2_period", 32'(period_out), 32'(P_A));
        wave(P_A, 1'b0, -1, 1'b1, 8'h00, 8'h20);
        check("t1_valid", 32'(note_valid), 32'd1);
        check("t1_period", 32'(period_out), 32'(P_A));
        check("t1_change_count", 32'(chg_total - base), 32'd1);

        for (int v = 0; v < 8; v++) begin
            base = chg_total;
            repeat (vecs[v].reps) wave(vecs[v].period, vecs[v].glitch, -1, 1'b0, 8'h00, 8'h00);
            check($sformatf("vec%0d_note", v), 32'(note_out), 32'(vecs[v].note));
            check($sformatf("vec%0d_valid", v), 32'(note_valid), 32'(|vecs[v].note));
            check($sformatf("vec%0d_period", v), 32'(period_out), 32'(vecs[v].per));
            check($sformatf("vec%0d_changes", v), 32'(chg_total - base), 32'(vecs[v].chg));
        end

        // Timeout: hold mid-scale after note A; k is the sample index since the last crossing.
        k    = P_A - 1;
        seen = 1'b0;
        while (!seen && k < int'(P_MAX) + 64) begin
            drv(8'h80);
            k++;
            if (note_change) seen = 1'b1;
        end
        check("timeout_seen", 32'(seen), 32'd1);
        check("timeout_when", 32'(k >= int'(P_MAX) - 1 && k <= int'(P_MAX) + 3), 32'd1);
        check("timeout_note", 32'(note_out), 32'd0);
        check("timeout_valid", 32'(note_valid), 32'd0);
        check("timeout_period_hold", 32'(period_out), 32'(P_A));
        drv(8'h80);
        base = chg_total;
        repeat (200) drv(8'h80);
        check("timeout_once", 32'(chg_total - base), 32'd0);
        wave(P_A, 1'b0, -1, 1'b0, 8'h00, 8'h00);
        check("retrain_cross1", 32'(note_out), 32'd0);
        wave(P_A, 1'b0, -1, 1'b0, 8'h00, 8'h00);
        check("retrain_cross2", 32'(note_out), 32'd0);
        wave(P_A, 1'b0, -1, 1'b1, 8'h00, 8'h20);

        // Async reset in the low half of a period with note A active.
        for (int i = 0; i < 600; i++) drv(wave_val(P_A, i, 1'b0));
        check("pre_reset_note", 32'(note_out), 32'h20);
        #2 rst_n = 1'b0;
        #1;
        check("async_note", 32'(note_out), 32'd0);
        check("async_valid", 32'(note_valid), 32'd0);
        check("async_change", 32'(note_change), 32'd0);
        check("async_period", 32'(period_out), 32'd0);
        repeat (3) drv(8'h00);
        rst_n = 1'b1;
        for (int i = 603; i < P_A; i++) drv(8'h00);
        wave(P_A, 1'b0, -1, 1'b0, 8'h00, 8'h00);
        check("post_reset_first_period", 32'(period_out), 32'd0);
        check("post_reset_first_note", 32'(note_out), 32'd0);
        wave(P_A, 1'b0, 600, 1'b0, 8'h00, 8'h00);
        check("post_reset_second_note", 32'(note_out), 32'd0);
        check("post_reset_second_period", 32'(period_out), 32'(P_A));
        wave(P_A, 1'b0, -1, 1'b1, 8'h00, 8'h20);
        check("ena_gap_period", 32'(period_out), 32'(P_A));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
